misr_param: RTL and testbench
=============================

MISR_PARAM -- requirements
Module: misr_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, signature register width in bits (legal range 2..32).
REQ-002 SHALL provide parameter IN_WIDTH, default 4, parallel input channel count (legal range 1..WIDTH).
REQ-003 SHALL provide parameter POLY, default 8'h1D, feedback tap mask of WIDTH bits; bit i set means a tap into stage i.
REQ-004 SHALL provide parameter SEED, default 0, WIDTH-bit signature value loaded at reset and at every start.
REQ-005 SHALL provide parameter CNT_W, default 8, width of the compaction-length counter.
REQ-006 SHALL have port clock  input  1  single clock, all state updates on the rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  input  1  begins a compaction run; sampled only in IDLE and DONE.
REQ-009 SHALL have port enable  input  1  when high in COMPACT, dataIn is compacted this cycle; when low, the run stalls.
REQ-010 SHALL have port dataIn  input  IN_WIDTH  response word to compact.
REQ-011 SHALL have port length  input  CNT_W  number of enabled cycles per run; sampled together with start.
REQ-012 SHALL have port golden  input  WIDTH  expected signature; compared on the final compaction.
REQ-013 SHALL have port dataOut  output  WIDTH  current signature register.
REQ-014 SHALL have port busy  output  1  high while in COMPACT.
REQ-015 SHALL have port done  output  1  high while in DONE.
REQ-016 SHALL have port pass  output  1  registered compare result, valid while done is high.

Function
REQ-017 SHALL implement the FSM states IDLE, COMPACT and DONE.
REQ-018 In IDLE or DONE, start=1 SHALL load sig<=SEED and cnt<=length, and SHALL clear pass.
REQ-019 On start, the FSM SHALL go to COMPACT if length!=0, or directly to DONE if length==0.
REQ-020 For a length==0 run, pass SHALL be (SEED==golden).
REQ-021 Each COMPACT cycle with enable=1 SHALL apply the update sig <= {sig[WIDTH-2:0],1'b0} ^ (sig[WIDTH-1] ? POLY : 0) ^ zero-extended dataIn, and SHALL decrement cnt.
REQ-022 A COMPACT cycle with enable=0 SHALL hold sig and cnt unchanged (stall, no timeout).
REQ-023 On the enabled cycle where cnt==1, the FSM SHALL go to DONE and capture pass <= (next sig == golden) on the same edge; done SHALL rise the following cycle.
REQ-024 start SHALL be ignored in COMPACT; a run cannot be aborted except by reset.
REQ-025 In DONE, sig, pass and done SHALL hold until start or reset; start in DONE restarts per REQ-018 with no idle cycle.
REQ-026 dataOut SHALL equal sig at all times (no output pipeline); busy and done SHALL be decoded from the state register, never both high.
REQ-027 All arithmetic SHALL be XOR/shift only; cnt SHALL never wrap, since decrement occurs only when cnt>=1.

Reset
REQ-028 reset=1 SHALL force state=IDLE, sig=SEED, cnt=0, pass=0 asynchronously, at any time including mid-run, so dataOut=SEED and busy=done=pass=0.
REQ-029 After reset deasserts, the block SHALL remain in IDLE until the first sampled start.

Verification (WIDTH=8, IN_WIDTH=4, POLY=8'h1D, SEED=0)
REQ-030 Basic run: start with length=3, golden=8'h03, dataIn 1,2,3 with enable=1 -> dataOut 01,00,03; done=1 and pass=1 after the third edge.
REQ-031 Feedback: SEED overridden to 8'h80, length=1, dataIn=0 -> dataOut=8'h1D; with golden=8'h1D -> pass=1.
REQ-032 Stall: the REQ-030 run with enable=0 for 2 cycles between words -> same signature 8'h03; busy high for 5 cycles; done delayed by 2 cycles.
REQ-033 Mismatch and zero-length: REQ-030 with golden=8'h04 -> done=1, pass=0; length=0 with golden=0 -> DONE next cycle, pass=1.
REQ-034 Reset mid-run: reset asserted after the 2nd compaction -> immediately dataOut=00 and busy=0; a later start reruns cleanly to 8'h03.
REQ-035 Back-to-back: start asserted in DONE -> sig reloads SEED and busy rises the next cycle; start pulses during COMPACT are ignored.

Source files
------------

// File: rtl/misr_param.sv
// misr_param: parameterised multiple-input signature register with a
// run controller. A run is started with a length; each enabled COMPACT
// cycle folds one parallel response word into the signature. The final
// signature is compared with an expected value, and the result is kept
// until the next start or reset.
//
// Handshake: there is no valid/ready pair. start is a level sampled on a
// rising edge only while the block is idle or done, and it is ignored
// while busy. enable acts as a per-cycle "data valid" while busy. A low
// enable stalls the run with no timeout, so the producer can pace the
// words freely.
module misr_param #(
  parameter int                 WIDTH    = 8,
  parameter int                 IN_WIDTH = 4,
  parameter logic [WIDTH-1:0]   POLY     = 8'h1D,
  parameter logic [WIDTH-1:0]   SEED     = '0,
  parameter int                 CNT_W    = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                enable,
  input  logic [IN_WIDTH-1:0] dataIn,
  input  logic [CNT_W-1:0]    length,
  input  logic [WIDTH-1:0]    golden,
  output logic [WIDTH-1:0]    dataOut,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPACT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sig_q,   sig_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              pass_q,  pass_d;

  // Signature value after folding in the current word. Only XOR and shift
  // are used: shift left, XOR the tap mask when the MSB falls out, then XOR
  // the zero-extended input word.
  logic [WIDTH-1:0]  sig_next;
  logic              last_word;
  logic              start_ok;

  // One compaction step of the signature register.
  always_comb begin
    sig_next = {sig_q[WIDTH-2:0], 1'b0}
             ^ (sig_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})
             ^ WIDTH'(dataIn);
  end

  // Qualifiers shared by the next-state and datapath logic.
  always_comb begin
    // The counter is never zero in COMPACT. The <= 1 test still makes sure
    // a corrupted zero count leaves the state instead of wrapping.
    last_word = (cnt_q <= CNT_W'(1));
    start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  end

  // State register: asynchronous reset to IDLE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic for the run controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = (length == '0) ? ST_DONE : ST_COMPACT;
        end
      end
      ST_COMPACT: begin
        if (enable && last_word) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode: busy and done come straight from the state register,
  // so they can never both be high.
  always_comb begin
    busy      = (state_q == ST_COMPACT);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Datapath next values: signature, remaining count and compare result.
  always_comb begin
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    pass_d = pass_q;
    if (start_ok) begin
      sig_d  = SEED;
      cnt_d  = length;
      // A zero-length run finishes on this edge, so the seed is the final
      // signature. Otherwise the result is cleared until the run completes.
      pass_d = (length == '0) ? (SEED == golden) : 1'b0;
    end else if ((state_q == ST_COMPACT) && enable) begin
      sig_d = sig_next;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
      if (last_word) begin
        pass_d = (sig_next == golden);
      end
    end
  end

  // Datapath registers: asynchronous reset to the seed, a zero count and a
  // cleared result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q  <= SEED;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      sig_q  <= sig_d;
      cnt_q  <= cnt_d;
      pass_q <= pass_d;
    end
  end

  // The signature register is visible directly, with no output pipeline.
  always_comb begin
    dataOut = sig_q;
    pass    = pass_q;
  end

endmodule

// File: tb/tb_misr_param.sv
// Bench for misr_param: directed scenarios plus randomized runs checked
// against a behavioural signature model.
module tb_misr_param;

  localparam logic [7:0] POLY = 8'h1D;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // main DUT (SEED = 0)
  logic       start = 0, enable = 0;
  logic [3:0] dataIn = '0;
  logic [7:0] length = '0, golden = '0;
  logic [7:0] dataOut;
  logic       busy, done, pass;
  logic [1:0] dbg_state;

  misr_param dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .dataIn(dataIn), .length(length), .golden(golden),
    .dataOut(dataOut), .busy(busy), .done(done), .pass(pass),
    .dbg_state(dbg_state)
  );

  // feedback DUT (SEED = 8'h80)
  logic       fb_start = 0, fb_enable = 0;
  logic [3:0] fb_dataIn = '0;
  logic [7:0] fb_length = '0, fb_golden = '0;
  logic [7:0] fb_dataOut;
  logic       fb_busy, fb_done, fb_pass;
  logic [1:0] fb_dbg_state;

  misr_param #(.SEED(8'h80)) dut_fb (
    .clock(clock), .reset(reset), .start(fb_start), .enable(fb_enable),
    .dataIn(fb_dataIn), .length(fb_length), .golden(fb_golden),
    .dataOut(fb_dataOut), .busy(fb_busy), .done(fb_done), .pass(fb_pass),
    .dbg_state(fb_dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model ----------------
  // Polynomial view: multiply the signature by x modulo the feedback
  // polynomial, then add (XOR) the new word.
  function automatic logic [7:0] model_step(input logic [7:0] s, input logic [3:0] d);
    int t;
    t = int'(s) * 2;
    if (t >= 256) t = (t - 256) ^ int'(POLY);
    return 8'(t) ^ {4'b0, d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_start(input logic [7:0] len, input logic [7:0] gold);
    start = 1; length = len; golden = gold; enable = 0;
    tick();
    start = 0;
  endtask

  task automatic drive_word(input logic [3:0] d);
    enable = 1; dataIn = d;
    tick();
    enable = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1;
    tick(); tick();
    n_vec++; if (dataOut !== 8'h00) begin n_err++; $display("FAIL reset_sig got=%h exp=00", dataOut); end
    n_vec++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin n_err++; $display("FAIL reset_flags got=%b%b%b exp=000", busy, done, pass); end
    n_vec++; if (fb_dataOut !== 8'h80) begin n_err++; $display("FAIL reset_fb_sig got=%h exp=80", fb_dataOut); end
    reset = 0;
    start = 0;
    tick(); tick();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL idle_hold got busy=%b done=%b exp=0 0", busy, done); end
  endtask

  task automatic test_basic();
    drive_start(8'd3, 8'h03);
    n_vec++; if (busy !== 1'b1 || dataOut !== 8'h00) begin n_err++; $display("FAIL basic_start got busy=%b sig=%h exp=1 00", busy, dataOut); end
    drive_word(4'd1);
    n_vec++; if (dataOut !== 8'h01) begin n_err++; $display("FAIL basic_w1 got=%h exp=01", dataOut); end
    drive_word(4'd2);
    n_vec++; if (dataOut !== 8'h00) begin n_err++; $display("FAIL basic_w2 got=%h exp=00", dataOut); end
    drive_word(4'd3);
    n_vec++; if (dataOut !== 8'h03) begin n_err++; $display("FAIL basic_w3 got=%h exp=03", dataOut); end
    n_vec++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL basic_done got done=%b pass=%b busy=%b exp=1 1 0", done, pass, busy); end
    tick(); tick();
    n_vec++; if (done !== 1'b1 || pass !== 1'b1 || dataOut !== 8'h03) begin n_err++; $display("FAIL basic_hold got done=%b pass=%b sig=%h exp=1 1 03", done, pass, dataOut); end
  endtask

  task automatic test_back_to_back();
    // currently DONE with pass=1; restart straight from DONE
    drive_start(8'd2, 8'h0C);
    n_vec++; if (busy !== 1'b1 || done !== 1'b0 || dataOut !== 8'h00 || pass !== 1'b0) begin
      n_err++; $display("FAIL b2b_reload got busy=%b done=%b sig=%h pass=%b exp=1 0 00 0", busy, done, dataOut, pass); end
    // start pulses during COMPACT must be ignored
    start = 1; length = 8'd9;
    enable = 1; dataIn = 4'd5; tick();
    n_vec++; if (dataOut !== 8'h05 || busy !== 1'b1) begin n_err++; $display("FAIL b2b_w1 got sig=%h busy=%b exp=05 1", dataOut, busy); end
    dataIn = 4'd6; tick();
    start = 0; enable = 0;
    n_vec++; if (dataOut !== 8'h0C || done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL b2b_end got sig=%h done=%b pass=%b exp=0c 1 1", dataOut, done, pass); end
  endtask

  task automatic test_stall();
    int busy_cycles;
    int cycles_to_done;
    logic [3:0] seq [5];
    logic       en  [5];
    seq = '{4'd1, 4'd0, 4'd2, 4'd0, 4'd3};
    en  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    drive_start(8'd3, 8'h03);
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    cycles_to_done = 0;
    for (int i = 0; i < 5; i++) begin
      enable = en[i]; dataIn = en[i] ? seq[i] : 4'hF;
      tick();
      cycles_to_done++;
      if (busy === 1'b1) busy_cycles++;
      if (i == 1) begin
        n_vec++; if (dataOut !== 8'h01) begin n_err++; $display("FAIL stall_hold got=%h exp=01", dataOut); end
      end
    end
    enable = 0;
    n_vec++; if (dataOut !== 8'h03 || done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL stall_end got sig=%h done=%b pass=%b exp=03 1 1", dataOut, done, pass); end
    n_vec++; if (busy_cycles != 5) begin n_err++; $display("FAIL stall_busy got=%0d exp=5", busy_cycles); end
    n_vec++; if (cycles_to_done != 5) begin n_err++; $display("FAIL stall_latency got=%0d exp=5", cycles_to_done); end
  endtask

  task automatic test_mismatch();
    drive_start(8'd3, 8'h04);
    drive_word(4'd1); drive_word(4'd2); drive_word(4'd3);
    n_vec++; if (done !== 1'b1 || pass !== 1'b0 || dataOut !== 8'h03) begin
      n_err++; $display("FAIL mismatch got done=%b pass=%b sig=%h exp=1 0 03", done, pass, dataOut); end
  endtask

  task automatic test_zero_len();
    drive_start(8'd0, 8'h00);
    n_vec++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || dataOut !== 8'h00) begin
      n_err++; $display("FAIL zero_len_match got done=%b pass=%b busy=%b sig=%h exp=1 1 0 00", done, pass, busy, dataOut); end
    drive_start(8'd0, 8'h5A);
    n_vec++; if (done !== 1'b1 || pass !== 1'b0) begin
      n_err++; $display("FAIL zero_len_miss got done=%b pass=%b exp=1 0", done, pass); end
  endtask

  task automatic test_reset_mid();
    drive_start(8'd3, 8'h03);
    drive_word(4'd1); drive_word(4'd6);
    n_vec++; if (dataOut !== 8'h04 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre got sig=%h busy=%b exp=04 1", dataOut, busy); end
    reset = 1;
    #2;
    n_vec++; if (dataOut !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      n_err++; $display("FAIL rmid_async got sig=%h busy=%b done=%b pass=%b exp=00 0 0 0", dataOut, busy, done, pass); end
    tick();
    reset = 0;
    tick(); tick();
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL rmid_idle got busy=%b done=%b exp=0 0", busy, done); end
    drive_start(8'd3, 8'h03);
    drive_word(4'd1); drive_word(4'd2); drive_word(4'd3);
    n_vec++; if (dataOut !== 8'h03 || done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL rmid_rerun got sig=%h done=%b pass=%b exp=03 1 1", dataOut, done, pass); end
  endtask

  task automatic test_feedback();
    fb_start = 1; fb_length = 8'd1; fb_golden = 8'h1D;
    tick();
    fb_start = 0;
    n_vec++; if (fb_dataOut !== 8'h80 || fb_busy !== 1'b1) begin n_err++; $display("FAIL fb_start got sig=%h busy=%b exp=80 1", fb_dataOut, fb_busy); end
    fb_enable = 1; fb_dataIn = 4'd0;
    tick();
    fb_enable = 0;
    n_vec++; if (fb_dataOut !== 8'h1D || fb_done !== 1'b1 || fb_pass !== 1'b1) begin
      n_err++; $display("FAIL fb_end got sig=%h done=%b pass=%b exp=1d 1 1", fb_dataOut, fb_done, fb_pass); end
  endtask

  task automatic test_random();
    for (int run = 0; run < 40; run++) begin
      int         len;
      int         remaining;
      int         guard;
      logic [7:0] exp_sig;
      logic [7:0] final_sig;
      logic [7:0] gold;
      logic [3:0] words [$];
      len = $urandom_range(0, 12);
      // precompute the words and the final signature up front
      exp_sig = 8'h00;
      words.delete();
      exp_q.delete();
      for (int k = 0; k < len; k++) begin
        words.push_back(4'($urandom_range(0, 15)));
        exp_sig = model_step(exp_sig, words[k]);
        exp_q.push_back(exp_sig);
      end
      final_sig = exp_sig;
      gold = ($urandom_range(0, 1) == 1) ? final_sig : 8'($urandom_range(0, 255));
      drive_start(8'(len), gold);
      remaining = len;
      exp_sig = 8'h00;
      guard = 0;
      while (remaining > 0 && guard < 200) begin
        enable = ($urandom_range(0, 3) != 0);
        dataIn = enable ? words[len - remaining] : 4'($urandom_range(0, 15));
        start  = ($urandom_range(0, 4) == 0);
        length = 8'($urandom_range(0, 255));
        tick();
        guard++;
        if (enable) begin
          exp_sig = exp_q.pop_front();
          remaining--;
        end
        n_vec++; if (dataOut !== exp_sig || busy !== (remaining > 0) || done !== (remaining == 0)) begin
          n_err++; $display("FAIL rand_step run=%0d got sig=%h busy=%b done=%b exp=%h %b %b",
                            run, dataOut, busy, done, exp_sig, remaining > 0, remaining == 0); end
      end
      start = 0; enable = 0;
      if (guard >= 200) begin
        n_vec++; n_err++; $display("FAIL rand_timeout run=%0d got=timeout exp=done", run);
      end
      n_vec++; if (done !== 1'b1 || dataOut !== final_sig || pass !== (final_sig == gold)) begin
        n_err++; $display("FAIL rand_end run=%0d got sig=%h done=%b pass=%b exp=%h 1 %b",
                          run, dataOut, done, pass, final_sig, final_sig == gold); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_mismatch();
    test_zero_len();
    test_reset_mid();
    test_feedback();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
